// File: rtl/count_capture_fifo_if.sv
// Head-of-FIFO drain handshake: valid/ready with FWFT data.
// The master drives data/valid; the slave drives ready.
interface count_capture_fifo_if #(
    parameter int DW = 16
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_capture_fifo.sv
// Captures {epoch, countin} on trigger rising edges into a FWFT FIFO; 1-cycle capture-to-valid latency.
// Drain is valid/ready; a capture into a full FIFO with no pop is dropped and sets sticky ovf.
// Optional CAPTURE_INHIBIT_EN: clockinh requests an upstream counter stall while full.
module count_capture_fifo #(
    parameter int WIDTH      = 10,
    parameter int EPOCH_BITS = 6,
    parameter int DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          countin,
    input  logic                      carryin,
    input  logic                      trigger,
    count_capture_fifo_if.master      q,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf,
    input  logic                      clear_ovf,
    output logic                      clockinh
);
    localparam int DW = EPOCH_BITS + WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
    logic                  trigger_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [DW-1:0]         mem_q [DEPTH];

    logic cap, pop, push, full, drop, not_empty;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign cap       = trigger & ~trigger_q;
    assign pop       = not_empty & q.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;

    always_comb begin
        epoch_d  = epoch_q + EPOCH_BITS'(carryin);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Drop beats clear when both land in the same cycle.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            epoch_q   <= '0;
            trigger_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            epoch_q   <= epoch_d;
            trigger_q <= trigger;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: validity is carried entirely by level/pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {epoch_q, countin};
        end
    end

    assign q.out_valid = not_empty;
    assign q.out_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level       = level_q;
    assign ovf         = ovf_q;

`ifdef CAPTURE_INHIBIT_EN
    logic clockinh_q, clockinh_d;

    assign clockinh_d = full;

    always_ff @(posedge clock) begin
        if (reset) begin
            clockinh_q <= 1'b0;
        end else begin
            clockinh_q <= clockinh_d;
        end
    end

    assign clockinh = clockinh_q;
`else
    assign clockinh = 1'b0;
`endif

endmodule
